// File: rtl/alu_multicycle_pkg.sv
// Shared opcode map, widths and FSM state type for the multicycle ALU.
package alu_multicycle_pkg;

  localparam int OPRN_W = 6;

  localparam logic [OPRN_W-1:0] OP_ADD  = 6'h01;
  localparam logic [OPRN_W-1:0] OP_SUB  = 6'h02;
  localparam logic [OPRN_W-1:0] OP_MUL  = 6'h03;
  localparam logic [OPRN_W-1:0] OP_SHR  = 6'h04;
  localparam logic [OPRN_W-1:0] OP_SHL  = 6'h05;
  localparam logic [OPRN_W-1:0] OP_AND  = 6'h06;
  localparam logic [OPRN_W-1:0] OP_OR   = 6'h07;
  localparam logic [OPRN_W-1:0] OP_NOR  = 6'h08;
  localparam logic [OPRN_W-1:0] OP_SLT  = 6'h09;
  localparam logic [OPRN_W-1:0] OP_DIVU = 6'h0A;
  localparam logic [OPRN_W-1:0] OP_REMU = 6'h0B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_multicycle_mul_div_iter.sv
// Iterative unsigned engine: shift-add multiply and restoring divide share one
// adder, one {hi,lo} accumulator pair and one down-counter.
module alu_multicycle_mul_div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  div_i,
  input  logic                  step_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] hi_nxt_o,
  output logic [DATA_WIDTH-1:0] lo_nxt_o,
  output logic                  last_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;

  logic [W:0]    opa, opb;
  logic          cin, ge;
  logic [W+1:0]  sum;

  // Divide: {rem,next dividend bit} - divisor via inverted operand, carry = no borrow.
  always_comb begin
    if (div_q) begin
      opa = {hi_q, lo_q[W-1]};
      opb = ~{1'b0, b_q};
      cin = 1'b1;
    end else begin
      opa = {1'b0, hi_q};
      opb = lo_q[0] ? {1'b0, b_q} : '0;
      cin = 1'b0;
    end
    sum = {1'b0, opa} + {1'b0, opb} + {{(W+1){1'b0}}, cin};
    ge  = sum[W+1];
    if (div_q) begin
      hi_d = ge ? sum[W-1:0] : opa[W-1:0];
      lo_d = {lo_q[W-2:0], ge};
    end else begin
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      div_q <= div_i;
      cnt_q <= CW'(W);
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign hi_nxt_o = hi_d;
  assign lo_nxt_o = lo_d;
  assign last_o   = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops complete the cycle after START, MUL/DIVU/REMU
// run DATA_WIDTH iterations in the shared engine. Results held until next DONE.
//   state   | meaning
//   ST_IDLE | accepting START; single-cycle ops complete from here
//   ST_EXEC | iterative op running, BUSY=1, START ignored
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = OPRN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [OPRN_WIDTH-1:0] oprn_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] out_o,
  output logic [DATA_WIDTH-1:0] out_hi_o,
  output logic                  zero_o,
  output logic                  err_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  state_e state_q, state_d;
  logic   accept, iter_op, load, step, fin, upd;
  logic   remu_q, dz_q;
  logic   done_q, zero_q, err_q;
  logic [DATA_WIDTH-1:0] out_q, out_hi_q;

  logic [DATA_WIDTH-1:0] md_hi, md_lo, sc_out, res_lo, res_hi;
  logic                  md_last, sc_err, res_err, shift_big;

  assign iter_op = (oprn_i == OPRN_WIDTH'(OP_MUL)) ||
                   (oprn_i == OPRN_WIDTH'(OP_DIVU)) ||
                   (oprn_i == OPRN_WIDTH'(OP_REMU));
  assign accept  = start_i && (state_q == ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && iter_op) state_d = ST_EXEC;
      ST_EXEC: if (md_last)           state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_EXEC);
    load   = accept && iter_op;
    step   = (state_q == ST_EXEC);
    fin    = step && md_last;
    upd    = fin || (accept && !iter_op);
  end

  alu_multicycle_mul_div_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .div_i    (oprn_i != OPRN_WIDTH'(OP_MUL)),
    .step_i   (step),
    .a_i      (op1_i),
    .b_i      (op2_i),
    .hi_nxt_o (md_hi),
    .lo_nxt_o (md_lo),
    .last_o   (md_last)
  );

  assign shift_big = (op2_i >= DATA_WIDTH'(DATA_WIDTH));

  always_comb begin
    sc_out = '0;
    sc_err = 1'b0;
    case (oprn_i)
      OPRN_WIDTH'(OP_ADD): sc_out = op1_i + op2_i;
      OPRN_WIDTH'(OP_SUB): sc_out = op1_i - op2_i;
      OPRN_WIDTH'(OP_SHR): sc_out = shift_big ? '0 : (op1_i >> op2_i[SHW-1:0]);
      OPRN_WIDTH'(OP_SHL): sc_out = shift_big ? '0 : (op1_i << op2_i[SHW-1:0]);
      OPRN_WIDTH'(OP_AND): sc_out = op1_i & op2_i;
      OPRN_WIDTH'(OP_OR):  sc_out = op1_i | op2_i;
      OPRN_WIDTH'(OP_NOR): sc_out = ~(op1_i | op2_i);
      OPRN_WIDTH'(OP_SLT): sc_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      default:             sc_err = 1'b1;
    endcase
  end

  // Engine leaves product as {hi,lo} and division as {rem,quot}; REMU swaps them.
  always_comb begin
    if (fin) begin
      res_lo  = remu_q ? md_hi : md_lo;
      res_hi  = remu_q ? md_lo : md_hi;
      res_err = dz_q;
    end else begin
      res_lo  = sc_out;
      res_hi  = '0;
      res_err = sc_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      remu_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        remu_q <= (oprn_i == OPRN_WIDTH'(OP_REMU));
        dz_q   <= (oprn_i != OPRN_WIDTH'(OP_MUL)) && (op2_i == '0);
      end
      done_q <= upd;
      if (upd) begin
        out_q    <= res_lo;
        out_hi_q <= res_hi;
        zero_q   <= (res_lo == '0);
        err_q    <= res_err;
      end
    end
  end

  assign done_o   = done_q;
  assign out_o    = out_q;
  assign out_hi_o = out_hi_q;
  assign zero_o   = zero_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at DATA_WIDTH=32 with hand-computed results.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  oprn;
  logic [31:0] op1, op2;
  logic        busy, done, zero, err;
  logic [31:0] out, out_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .oprn_i   (oprn),
    .op1_i    (op1),
    .op2_i    (op2),
    .busy_o   (busy),
    .done_o   (done),
    .out_o    (out),
    .out_hi_o (out_hi),
    .zero_o   (zero),
    .err_o    (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge; lat counts cycles from START edge to DONE cycle.
  // glitch_at>0 pulses a bogus START (ADD 1,1) during that BUSY cycle.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at, output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; oprn = op; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0; oprn = 6'h00; op1 = '0; op2 = '0;
    lat = 1; nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      if (glitch_at > 0 && nbusy == glitch_at) begin
        start = 1'b1; oprn = 6'h01; op1 = 32'd1; op2 = 32'd1;
      end
      @(negedge clk);
      start = 1'b0; oprn = 6'h00; op1 = '0; op2 = '0;
      lat++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int lat, nb;
    logic saw_done;
    rst = 1'b1; start = 1'b0; oprn = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_out", {32'd0, out}, 64'd0);
    check("rst_out_hi", {32'd0, out_hi}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;

    // Back-to-back ADD then SUB
    @(negedge clk);
    start = 1'b1; oprn = 6'h01; op1 = 32'd15; op2 = 32'hFFFF_FFFB;
    @(negedge clk);
    check("add_done", {63'd0, done}, 64'd1);
    check("add_out", {32'd0, out}, 64'd10);
    check("add_zero", {63'd0, zero}, 64'd0);
    oprn = 6'h02; op1 = 32'd5; op2 = 32'd15;
    @(negedge clk);
    start = 1'b0;
    check("sub_done", {63'd0, done}, 64'd1);
    check("sub_out", {32'd0, out}, 64'hFFFF_FFF6);
    check("sub_zero", {63'd0, zero}, 64'd0);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);
    check("out_hold", {32'd0, out}, 64'hFFFF_FFF6);

    run_op(6'h03, 32'hFFFF_FFFF, 32'd2, 0, lat, nb);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_busy", 64'(nb), 64'd32);
    check("mul_busy_done", {63'd0, busy}, 64'd0);
    check("mul_out", {32'd0, out}, 64'hFFFF_FFFE);
    check("mul_hi", {32'd0, out_hi}, 64'd1);
    check("mul_err", {63'd0, err}, 64'd0);

    run_op(6'h0A, 32'd100, 32'd7, 10, lat, nb);
    check("divu_lat", 64'(lat), 64'd33);
    check("divu_out", {32'd0, out}, 64'd14);
    check("divu_hi", {32'd0, out_hi}, 64'd2);
    check("divu_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    check("divu_glitch_ignored", {63'd0, done}, 64'd0);

    run_op(6'h0A, 32'd9, 32'd0, 0, lat, nb);
    check("dz_lat", 64'(lat), 64'd33);
    check("dz_out", {32'd0, out}, 64'hFFFF_FFFF);
    check("dz_hi", {32'd0, out_hi}, 64'd9);
    check("dz_err", {63'd0, err}, 64'd1);

    run_op(6'h0B, 32'd100, 32'd7, 0, lat, nb);
    check("remu_out", {32'd0, out}, 64'd2);
    check("remu_hi", {32'd0, out_hi}, 64'd14);
    check("remu_err", {63'd0, err}, 64'd0);

    run_op(6'h05, 32'd1, 32'd32, 0, lat, nb);
    check("shl32_lat", 64'(lat), 64'd1);
    check("shl32_out", {32'd0, out}, 64'd0);
    check("shl32_zero", {63'd0, zero}, 64'd1);
    run_op(6'h05, 32'd1, 32'd31, 0, lat, nb);
    check("shl31_out", {32'd0, out}, 64'h8000_0000);
    run_op(6'h04, 32'h8000_0000, 32'd4, 0, lat, nb);
    check("shr4_out", {32'd0, out}, 64'h0800_0000);
    run_op(6'h09, 32'hFFFF_FFFF, 32'd5, 0, lat, nb);
    check("slt_neg_out", {32'd0, out}, 64'd1);
    run_op(6'h09, 32'd5, 32'hFFFF_FFFF, 0, lat, nb);
    check("slt_pos_out", {32'd0, out}, 64'd0);
    check("slt_pos_zero", {63'd0, zero}, 64'd1);
    run_op(6'h08, 32'h0, 32'h0, 0, lat, nb);
    check("nor_out", {32'd0, out}, 64'hFFFF_FFFF);
    run_op(6'h07, 32'h00F0, 32'h0F00, 0, lat, nb);
    check("or_out", {32'd0, out}, 64'h0FF0);

    run_op(6'h3F, 32'd3, 32'd4, 0, lat, nb);
    check("bad_err", {63'd0, err}, 64'd1);
    check("bad_out", {32'd0, out}, 64'd0);
    check("bad_hi", {32'd0, out_hi}, 64'd0);
    run_op(6'h06, 32'hF0F0, 32'hFF00, 0, lat, nb);
    check("and_out", {32'd0, out}, 64'hF000);
    check("and_err", {63'd0, err}, 64'd0);

    // Reset during the fifth BUSY cycle of a MUL
    @(negedge clk);
    start = 1'b1; oprn = 6'h03; op1 = 32'd3; op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_out", {32'd0, out}, 64'd0);
    check("midrst_zero", {63'd0, zero}, 64'd1);
    check("midrst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_no_done", {63'd0, saw_done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
